// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one memory bus between fetch (port 0) and LSU (port 1).
// Defining MEM_ARB_TIMEOUT_EN adds a watchdog that ends stalled bus transactions with err_o.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][3:0]  sel_i,
    input  logic [1:0][31:0] wdata_i,
    output logic [1:0]       ack_o,
    output logic [1:0]       err_o,
    output logic [31:0]      rdata_o,
    output logic [1:0]       grant_o,
    output logic             bus_cyc_o,
    output logic [31:0]      bus_addr_o,
    output logic             bus_we_o,
    output logic [3:0]       bus_sel_o,
    output logic [31:0]      bus_wdata_o,
    input  logic             bus_ack_i,
    input  logic [31:0]      bus_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic        last_grant_reg;
    logic [1:0]  ack_reg;
    logic [1:0]  grant_reg;
    logic [31:0] rdata_reg;
    logic        bus_cyc_reg;
    logic [31:0] bus_addr_reg;
    logic        bus_we_reg;
    logic [3:0]  bus_sel_reg;
    logic [31:0] bus_wdata_reg;
    logic        win_idx;

    // A lone request wins outright; on a tie the port that did not win last time goes.
    always_comb begin
        win_idx = 1'b0;
        if (req_i == 2'b10) begin
            win_idx = 1'b1;
        end else if (req_i == 2'b11) begin
            win_idx = ~last_grant_reg;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_reg;
    logic [1:0]       err_reg;
    logic             tmo_hit;

    // Counter holds the number of ack-less BUSY cycles already completed.
    assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || state_reg != ST_BUSY) begin
            tmo_cnt_reg <= '0;
        end else if (!bus_ack_i) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 2'b00;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            ack_reg        <= 2'b00;
            grant_reg      <= 2'b00;
            rdata_reg      <= '0;
            bus_cyc_reg    <= 1'b0;
            bus_addr_reg   <= '0;
            bus_we_reg     <= 1'b0;
            bus_sel_reg    <= '0;
            bus_wdata_reg  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_reg        <= 2'b00;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req_i) begin
                        bus_addr_reg   <= addr_i[win_idx];
                        bus_we_reg     <= we_i[win_idx];
                        bus_sel_reg    <= sel_i[win_idx];
                        bus_wdata_reg  <= wdata_i[win_idx];
                        bus_cyc_reg    <= 1'b1;
                        grant_reg      <= win_idx ? 2'b10 : 2'b01;
                        last_grant_reg <= win_idx;
                        state_reg      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack_i) begin
                        rdata_reg   <= bus_rdata_i;
                        ack_reg     <= grant_reg;
                        bus_cyc_reg <= 1'b0;
                        state_reg   <= ST_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rdata_reg   <= '0;
                        err_reg     <= grant_reg;
                        bus_cyc_reg <= 1'b0;
                        state_reg   <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    // One-cycle response window lets the requester drop req_i before IDLE samples it.
                    ack_reg   <= 2'b00;
                    grant_reg <= 2'b00;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_reg   <= 2'b00;
`endif
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_reg;
    assign rdata_o     = rdata_reg;
    assign grant_o     = grant_reg;
    assign bus_cyc_o   = bus_cyc_reg;
    assign bus_addr_o  = bus_addr_reg;
    assign bus_we_o    = bus_we_reg;
    assign bus_sel_o   = bus_sel_reg;
    assign bus_wdata_o = bus_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model queues expected
// bus commands and responses, and an independent monitor checks the DUT against them.
module tb_mem_port_arbiter;

    localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int STEPS = 4600;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [1:0]       req_i;
    logic [1:0][31:0] addr_i;
    logic [1:0]       we_i;
    logic [1:0][3:0]  sel_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       ack_o;
    logic [1:0]       err_o;
    logic [31:0]      rdata_o;
    logic [1:0]       grant_o;
    logic             bus_cyc_o;
    logic [31:0]      bus_addr_o;
    logic             bus_we_o;
    logic [3:0]       bus_sel_o;
    logic [31:0]      bus_wdata_o;
    logic             bus_ack_i;
    logic [31:0]      bus_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .sel_i(sel_i), .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .grant_o(grant_o), .bus_cyc_o(bus_cyc_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [1:0]  grant;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [1:0]  grant;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_cyc = 1'b0;

    // Transaction-level model state
    int   m_phase;      // 0 idle, 1 bus owned, 2 response cycle
    int   m_last;
    int   m_owner;
    int   m_wait;
    bit   pending[2];
    int   slave_cnt;
    int   slave_target;
    bit   force_long;
    int   cur_step;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_rsp(input bit is_err, input logic [31:0] data);
        rsp_t r;
        r.ack   = is_err ? 2'b00 : 2'(1 << m_owner);
        r.err   = is_err ? 2'(1 << m_owner) : 2'b00;
        r.grant = 2'(1 << m_owner);
        r.rdata = data;
        rsp_q.push_back(r);
        pending[m_owner] = 1'b0;
        m_phase = 2;
    endtask

    // Advances the model across the clock edge that just sampled the current inputs.
    task automatic model_step();
        cmd_t c;
        int   w;
        if (rst_i) begin
            m_phase = 0;
            m_last  = 1;
            m_wait  = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (req_i != 2'b00) begin
                    if (req_i == 2'b11) w = (m_last == 1) ? 0 : 1;
                    else                w = req_i[1] ? 1 : 0;
                    c.addr  = addr_i[w];
                    c.we    = we_i[w];
                    c.sel   = sel_i[w];
                    c.wdata = wdata_i[w];
                    c.grant = 2'(1 << w);
                    cmd_q.push_back(c);
                    m_owner   = w;
                    m_last    = w;
                    m_wait    = 0;
                    m_phase   = 1;
                    slave_cnt = 0;
                    if (force_long) begin
                        slave_target = 1200;
                        force_long   = 1'b0;
                    end else if (cur_step < 40) begin
                        slave_target = 0;
                    end else begin
                        slave_target = $urandom_range(0, 6);
                    end
                end
            end
            1: begin
                if (bus_ack_i) begin
                    finish_rsp(1'b0, bus_rdata_i);
                end else begin
                    m_wait++;
                    if (TMO_EN && m_wait >= TMO) finish_rsp(1'b1, 32'h0);
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic drive(input int step);
        exp_cyc = (m_phase == 1);
        for (int p = 0; p < 2; p++) begin
            if (!pending[p] && (step < 40 || $urandom_range(0, 1) == 1)) begin
                pending[p] = 1'b1;
                addr_i[p]  = $urandom;
                we_i[p]    = 1'($urandom_range(0, 1));
                sel_i[p]   = 4'($urandom_range(0, 15));
                wdata_i[p] = $urandom;
            end else if (m_phase == 1 && m_owner == p && $urandom_range(0, 3) == 0) begin
                // Owner payload changes after grant must not reach the bus.
                addr_i[p]  = $urandom;
                we_i[p]    = ~we_i[p];
                sel_i[p]   = 4'($urandom_range(0, 15));
                wdata_i[p] = $urandom;
            end
            req_i[p] = pending[p];
        end
        bus_rdata_i = $urandom;
        if (m_phase == 1) begin
            bus_ack_i = (slave_cnt == slave_target);
            slave_cnt++;
        end else begin
            bus_ack_i = ($urandom_range(0, 3) == 0);
        end
        if (step < 2 || step >= STEPS - 6) rst_i = 1'b1;
        else if (step >= 40 && step < 3000) rst_i = ($urandom_range(0, 49) == 0);
        else rst_i = 1'b0;
        if (step == 3000) force_long = 1'b1;
    endtask

    // Stimulus and reference model
    initial begin
        rst_i       = 1'b1;
        req_i       = 2'b00;
        addr_i      = '0;
        we_i        = 2'b00;
        sel_i       = '0;
        wdata_i     = '0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        m_phase     = 0;
        m_last      = 1;
        m_owner     = 0;
        m_wait      = 0;
        pending[0]  = 1'b0;
        pending[1]  = 1'b0;
        slave_cnt   = 0;
        slave_target = 0;
        force_long  = 1'b0;
        for (int step = 0; step < STEPS; step++) begin
            cur_step = step;
            @(posedge clk);
            #1;
            model_step();
            drive(step);
        end
        @(negedge clk);
        #1;
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Monitor: compares DUT outputs against queued expectations, mid-cycle.
    initial begin
        cmd_t cur;
        rsp_t r;
        logic prev_cyc;
        logic rst_seen;
        cur      = '0;
        prev_cyc = 1'b0;
        forever begin
            @(posedge clk);
            rst_seen = rst_i;
            @(negedge clk);
            if (rst_seen) begin
                chk("rst_ctrl", {56'd0, ack_o, err_o, grant_o, bus_cyc_o, bus_we_o}, 64'd0);
                chk("rst_addr", 64'(bus_addr_o), 64'd0);
                chk("rst_sel_wdata", {28'd0, bus_sel_o, bus_wdata_o}, 64'd0);
                chk("rst_rdata", 64'(rdata_o), 64'd0);
            end else begin
                chk("bus_cyc", 64'(bus_cyc_o), 64'(exp_cyc));
                if (bus_cyc_o && !prev_cyc) begin
                    chk("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
                    if (cmd_q.size() != 0) cur = cmd_q.pop_front();
                end
                if (bus_cyc_o) begin
                    chk("bus_addr", 64'(bus_addr_o), 64'(cur.addr));
                    chk("bus_we_sel", {59'd0, bus_we_o, bus_sel_o}, {59'd0, cur.we, cur.sel});
                    chk("bus_wdata", 64'(bus_wdata_o), 64'(cur.wdata));
                    chk("grant_busy", 64'(grant_o), 64'(cur.grant));
                end
                if (ack_o != 2'b00 || err_o != 2'b00) begin
                    chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        chk("ack", 64'(ack_o), 64'(r.ack));
                        chk("err", 64'(err_o), 64'(r.err));
                        chk("rdata", 64'(rdata_o), 64'(r.rdata));
                        chk("grant_resp", 64'(grant_o), 64'(r.grant));
                    end
                end else if (!bus_cyc_o) begin
                    chk("grant_idle", 64'(grant_o), 64'd0);
                end
            end
            chk("cmd_pending", 64'(cmd_q.size()), 64'd0);
            chk("rsp_pending", 64'(rsp_q.size()), 64'd0);
            prev_cyc = bus_cyc_o;
        end
    end

endmodule
